sw_lap_ctrl: RTL and testbench



---
 rtl/sw_pkg.sv | 17 +
 rtl/sw_lap_fifo.sv | 58 +++++
 rtl/sw_lap_ctrl.sv | 125 ++++++++++++
 tb/tb_sw_lap_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared state encoding for the stopwatch lap controller.
package sw_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        STWAIT = 4'd2,
        RUN    = 4'd3,
        RCLEAR = 4'd4,
        SPWAIT = 4'd5,
        STOP   = 4'd6,
        ICLEAR = 4'd7,
        LAP    = 4'd8,
        LWAIT  = 4'd9
    } sw_state_e;

endpackage

// File: rtl/sw_lap_fifo.sv
// Lap capture FIFO: wrap-around pointers, head read combinationally, clear dominates pop/push.
module sw_lap_fifo #(
    parameter int CNT_W     = 16,
    parameter int LAP_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  logic [CNT_W-1:0]                 din_i,
    output logic [CNT_W-1:0]                 dout_o,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   cnt_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic                             drop_o
);

    localparam int CW    = $clog2(LAP_DEPTH + 1);
    localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    logic [CNT_W-1:0] mem_q [LAP_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             pop_ok, push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LAP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(LAP_DEPTH));
    assign cnt_o   = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A full buffer still accepts a push when the same cycle pops the head.
    assign pop_ok  = pop_i && !empty_o && !clr_i;
    assign push_ok = push_i && !clr_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !clr_i && full_o && !pop_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + CW'(1);
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/sw_lap_ctrl.sv
// Stopwatch controller: start/stop/clear/lap FSM, prescaled elapsed counter and lap FIFO.
module sw_lap_ctrl
    import sw_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int TICK_DIV  = 100000,
    parameter int LAP_DEPTH = 4,
    parameter int WRAP_EN   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             c_btn,
    input  logic                             ss_btn,
    input  logic                             lap_btn,
    input  logic                             db_done,
    input  logic                             lap_rd,
    output logic                             strt_pls,
    output logic                             tmr_on,
    output logic                             tmr_clr,
    output logic [CNT_W-1:0]                 elapsed,
    output logic [CNT_W-1:0]                 lap_dout,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_cnt,
    output logic                             lap_empty,
    output logic                             lap_full,
    output logic                             lap_ovf,
    output logic                             cnt_wrap,
    output logic [3:0]                       state_dbg
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    sw_state_e        state_q, state_d;
    logic             strt_pls_q, tmr_on_q, tmr_clr_q;
    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] elapsed_q;
    logic             lap_ovf_q, cnt_wrap_q;
    logic             tick, lap_push, lap_drop;

    // Handshake: strt_pls restarts the debouncer; the FSM then holds in a wait
    // state, ignoring buttons, until db_done is seen high on a clock edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (c_btn) state_d = ICLEAR; else if (ss_btn) state_d = START;
            ICLEAR:  state_d = IDLE;
            START:   state_d = STWAIT;
            STWAIT:  if (db_done) state_d = RUN;
            RUN: begin
                if (c_btn)        state_d = RCLEAR;
                else if (ss_btn)  state_d = STOP;
                else if (lap_btn) state_d = LAP;
            end
            RCLEAR:  state_d = RUN;
            STOP:    state_d = SPWAIT;
            SPWAIT:  if (db_done) state_d = IDLE;
            LAP:     state_d = LWAIT;
            LWAIT:   if (db_done) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            strt_pls_q <= 1'b0;
            tmr_on_q   <= 1'b0;
            tmr_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            strt_pls_q <= (state_d inside {START, STOP, LAP});
            tmr_on_q   <= (state_d inside {START, STWAIT, RUN, RCLEAR, LAP, LWAIT});
            tmr_clr_q  <= (state_d inside {ICLEAR, RCLEAR});
        end
    end

    assign tick     = tmr_on_q && (pre_q == PRE_W'(TICK_DIV - 1));
    assign lap_push = (state_q == LAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || tmr_clr_q) begin
            pre_q      <= '0;
            elapsed_q  <= '0;
            lap_ovf_q  <= 1'b0;
            cnt_wrap_q <= 1'b0;
        end else begin
            if (tmr_on_q) pre_q <= tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                if (&elapsed_q) begin
                    cnt_wrap_q <= 1'b1;
                    if (WRAP_EN != 0) elapsed_q <= '0;
                end else begin
                    elapsed_q <= elapsed_q + CNT_W'(1);
                end
            end
            if (lap_drop) lap_ovf_q <= 1'b1;
        end
    end

    sw_lap_fifo #(
        .CNT_W     (CNT_W),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (tmr_clr_q),
        .push_i  (lap_push),
        .pop_i   (lap_rd),
        .din_i   (elapsed_q),
        .dout_o  (lap_dout),
        .cnt_o   (lap_cnt),
        .full_o  (lap_full),
        .empty_o (lap_empty),
        .drop_o  (lap_drop)
    );

    assign strt_pls  = strt_pls_q;
    assign tmr_on    = tmr_on_q;
    assign tmr_clr   = tmr_clr_q;
    assign elapsed   = elapsed_q;
    assign lap_ovf   = lap_ovf_q;
    assign cnt_wrap  = cnt_wrap_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sw_lap_ctrl.sv
// Bench for sw_lap_ctrl: a wrapping and a saturating instance against a queue-based reference.
module tb_sw_lap_ctrl;

    localparam int CNT_W = 4;
    localparam int TICK_DIV = 4;
    localparam int LAP_DEPTH = 2;
    localparam int MAXV = (1 << CNT_W) - 1;
    localparam int LCW = $clog2(LAP_DEPTH + 1);

    localparam int M_IDLE = 0, M_START = 1, M_STWAIT = 2, M_RUN = 3, M_RCLEAR = 4;
    localparam int M_SPWAIT = 5, M_STOP = 6, M_ICLEAR = 7, M_LAP = 8, M_LWAIT = 9;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic c_btn, ss_btn, lap_btn, db_done, lap_rd;

    logic             strt_pls, tmr_on, tmr_clr, lap_empty, lap_full, lap_ovf, cnt_wrap;
    logic [CNT_W-1:0] elapsed, lap_dout;
    logic [LCW-1:0]   lap_cnt;
    logic [3:0]       state_dbg;

    logic             s_strt, s_on, s_clr, s_empty, s_full, s_ovf, s_wrap;
    logic [CNT_W-1:0] s_el, s_dout;
    logic [LCW-1:0]   s_cnt;
    logic [3:0]       s_state;

    sw_lap_ctrl #(.CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH), .WRAP_EN(1)) u_dut (
        .clk(clk), .rst(rst), .c_btn(c_btn), .ss_btn(ss_btn), .lap_btn(lap_btn),
        .db_done(db_done), .lap_rd(lap_rd), .strt_pls(strt_pls), .tmr_on(tmr_on),
        .tmr_clr(tmr_clr), .elapsed(elapsed), .lap_dout(lap_dout), .lap_cnt(lap_cnt),
        .lap_empty(lap_empty), .lap_full(lap_full), .lap_ovf(lap_ovf), .cnt_wrap(cnt_wrap),
        .state_dbg(state_dbg)
    );

    sw_lap_ctrl #(.CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH), .WRAP_EN(0)) u_sat (
        .clk(clk), .rst(rst), .c_btn(c_btn), .ss_btn(ss_btn), .lap_btn(lap_btn),
        .db_done(db_done), .lap_rd(lap_rd), .strt_pls(s_strt), .tmr_on(s_on),
        .tmr_clr(s_clr), .elapsed(s_el), .lap_dout(s_dout), .lap_cnt(s_cnt),
        .lap_empty(s_empty), .lap_full(s_full), .lap_ovf(s_ovf), .cnt_wrap(s_wrap),
        .state_dbg(s_state)
    );

    // reference model
    int ms, pre, el_w, el_s, wrap_w, wrap_s, ovf;
    int lq[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit runs(input int s);
        return s == M_START || s == M_STWAIT || s == M_RUN || s == M_RCLEAR || s == M_LAP || s == M_LWAIT;
    endfunction

    function automatic bit pulses(input int s);
        return s == M_START || s == M_STOP || s == M_LAP;
    endfunction

    function automatic bit clears(input int s);
        return s == M_ICLEAR || s == M_RCLEAR;
    endfunction

    task automatic model_reset();
        ms = M_IDLE; pre = 0; el_w = 0; el_s = 0; wrap_w = 0; wrap_s = 0; ovf = 0;
        lq.delete();
    endtask

    // One clock edge of the stopwatch as the user sees it, using the inputs now driven.
    task automatic model_advance();
        int ns;
        int snap;
        ns = ms;
        snap = el_w;
        if (clears(ms)) begin
            pre = 0; el_w = 0; el_s = 0; wrap_w = 0; wrap_s = 0; ovf = 0;
            lq.delete();
        end else begin
            if (lap_rd && lq.size() > 0) void'(lq.pop_front());
            if (ms == M_LAP) begin
                if (lq.size() < LAP_DEPTH) lq.push_back(snap);
                else ovf = 1;
            end
            if (runs(ms)) begin
                pre++;
                if (pre == TICK_DIV) begin
                    pre = 0;
                    if (el_w == MAXV) begin el_w = 0; wrap_w = 1; end else el_w++;
                    if (el_s == MAXV) wrap_s = 1; else el_s++;
                end
            end
        end
        case (ms)
            M_IDLE:   ns = c_btn ? M_ICLEAR : (ss_btn ? M_START : M_IDLE);
            M_ICLEAR: ns = M_IDLE;
            M_START:  ns = M_STWAIT;
            M_STWAIT: ns = db_done ? M_RUN : M_STWAIT;
            M_RUN:    ns = c_btn ? M_RCLEAR : (ss_btn ? M_STOP : (lap_btn ? M_LAP : M_RUN));
            M_RCLEAR: ns = M_RUN;
            M_STOP:   ns = M_SPWAIT;
            M_SPWAIT: ns = db_done ? M_IDLE : M_SPWAIT;
            M_LAP:    ns = M_LWAIT;
            M_LWAIT:  ns = db_done ? M_RUN : M_LWAIT;
            default:  ns = M_IDLE;
        endcase
        ms = ns;
    endtask

    task automatic check_all();
        check_eq("state", state_dbg, ms);
        check_eq("tmr_on", tmr_on, runs(ms));
        check_eq("strt_pls", strt_pls, pulses(ms));
        check_eq("tmr_clr", tmr_clr, clears(ms));
        check_eq("elapsed", elapsed, el_w);
        check_eq("lap_cnt", lap_cnt, lq.size());
        check_eq("lap_empty", lap_empty, lq.size() == 0);
        check_eq("lap_full", lap_full, lq.size() == LAP_DEPTH);
        check_eq("lap_dout", lap_dout, (lq.size() > 0) ? lq[0] : 0);
        check_eq("lap_ovf", lap_ovf, ovf);
        check_eq("cnt_wrap", cnt_wrap, wrap_w);
        check_eq("sat_state", s_state, ms);
        check_eq("sat_elapsed", s_el, el_s);
        check_eq("sat_cnt_wrap", s_wrap, wrap_s);
    endtask

    // driver tasks: drive one cycle of inputs, then check after the edge
    task automatic cyc(input logic c, input logic ss, input logic lp, input logic dd, input logic rd);
        c_btn = c; ss_btn = ss; lap_btn = lp; db_done = dd; lap_rd = rd;
        model_advance();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic handshake();
        idle_cycles(2);
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic wait_run_el(input int target);
        int n;
        n = 0;
        while (!(ms == M_RUN && el_w == target) && n < 200) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        if (n >= 200) check_eq("wait_run_el_timeout", el_w, target);
    endtask

    task automatic do_lap(input int target);
        wait_run_el(target);
        cyc(0, 0, 1, 0, 0);
        handshake();
    endtask

    initial begin
        rst = 1'b1;
        c_btn = 0; ss_btn = 0; lap_btn = 0; db_done = 0; lap_rd = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // start and run
        cyc(0, 1, 0, 0, 0);
        handshake();
        idle_cycles(16);

        // stop, then resume from the frozen value
        cyc(0, 1, 0, 0, 0);
        handshake();
        idle_cycles(6);
        cyc(0, 1, 0, 0, 0);
        handshake();
        idle_cycles(8);

        // clear while running at elapsed=5
        wait_run_el(5);
        cyc(1, 0, 0, 0, 0);
        idle_cycles(10);

        // lap overflow, then drain past empty
        cyc(1, 0, 0, 0, 0);
        do_lap(2);
        do_lap(5);
        do_lap(9);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        idle_cycles(2);

        // full buffer with a read in the capture cycle
        cyc(1, 0, 0, 0, 0);
        do_lap(3);
        do_lap(6);
        wait_run_el(10);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        idle_cycles(3);

        // run past the counter limit
        wait_run_el(MAXV);
        idle_cycles(12);

        // asynchronous reset while waiting for the debouncer
        cyc(0, 1, 0, 0, 0);
        handshake();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_state", state_dbg, M_IDLE);
        check_eq("arst_tmr_on", tmr_on, 0);
        check_eq("arst_strt_pls", strt_pls, 0);
        check_eq("arst_elapsed", elapsed, 0);
        check_eq("arst_lap_cnt", lap_cnt, 0);
        check_eq("arst_lap_empty", lap_empty, 1);
        check_eq("arst_cnt_wrap", cnt_wrap, 0);
        model_reset();
        c_btn = 0; ss_btn = 0; lap_btn = 0; db_done = 0; lap_rd = 0;
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // randomized operation
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
